// File: rtl/bootrom_ctrl_if.sv
// Request/response bundle between the fetch/load units, the boot ROM
// sequencer and the boot ROM itself.
interface bootrom_ctrl_if #(
    parameter int ADDR_W = 9,
    parameter int TAG_W  = 4
) ();
    logic              if_req_valid;
    logic              if_req_ready;
    logic [ADDR_W-1:0] if_req_addr;
    logic [TAG_W-1:0]  if_req_tag;
    logic              if_rsp_valid;
    logic              if_rsp_ready;
    logic [127:0]      if_rsp_data;
    logic [TAG_W-1:0]  if_rsp_tag;

    logic              ld_req_valid;
    logic              ld_req_ready;
    logic [ADDR_W+3:0] ld_req_addr;
    logic [1:0]        ld_req_size;
    logic [TAG_W-1:0]  ld_req_tag;
    logic              ld_rsp_valid;
    logic              ld_rsp_ready;
    logic [63:0]       ld_rsp_data;
    logic              ld_rsp_err;
    logic [TAG_W-1:0]  ld_rsp_tag;

    logic [ADDR_W-1:0] rom_addr;
    logic [127:0]      rom_data;

    modport slave (
        input  if_req_valid, if_req_addr, if_req_tag, if_rsp_ready,
        input  ld_req_valid, ld_req_addr, ld_req_size, ld_req_tag,
        input  ld_rsp_ready, rom_data,
        output if_req_ready, if_rsp_valid, if_rsp_data, if_rsp_tag,
        output ld_req_ready, ld_rsp_valid, ld_rsp_data, ld_rsp_err,
        output ld_rsp_tag, rom_addr
    );

    modport master (
        output if_req_valid, if_req_addr, if_req_tag, if_rsp_ready,
        output ld_req_valid, ld_req_addr, ld_req_size, ld_req_tag,
        output ld_rsp_ready, rom_data,
        input  if_req_ready, if_rsp_valid, if_rsp_data, if_rsp_tag,
        input  ld_req_ready, ld_rsp_valid, ld_rsp_data, ld_rsp_err,
        input  ld_rsp_tag, rom_addr
    );
endinterface

// File: rtl/bootrom_ctrl.sv
// Boot ROM sequencer: round-robin shares the 128-bit ROM between
// instruction fetch (whole lines) and the load unit (1/2/4/8 bytes).
module bootrom_ctrl #(
    parameter int ADDR_W = 9,
    parameter int TAG_W  = 4
) (
    input logic           clk,
    input logic           reset,
    bootrom_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, READ, RESP} state_t;

    state_t           state;
    logic             last_ld;
    logic             cur_ld;
    logic [TAG_W-1:0] cur_tag;
    logic [1:0]       cur_size;
    logic [3:0]       cur_off;

    logic             idle;
    logic             gnt_if;
    logic             gnt_ld;
    logic [63:0]      win;
    logic [63:0]      ld_data;
    logic             misal;
    logic             rsp_done;

    assign idle = (state == IDLE) && !reset;

    // On conflict the port that did not win last time is served.
    always_comb begin
        gnt_if = 1'b0;
        gnt_ld = 1'b0;
        if (idle) begin
            if (bus.if_req_valid && bus.ld_req_valid) begin
                gnt_if = last_ld;
                gnt_ld = !last_ld;
            end else begin
                gnt_if = bus.if_req_valid;
                gnt_ld = bus.ld_req_valid;
            end
        end
    end

    assign bus.if_req_ready = gnt_if;
    assign bus.ld_req_ready = gnt_ld;

    always_comb begin
        win     = 64'(bus.rom_data >> {cur_off, 3'b000});
        ld_data = '0;
        misal   = 1'b0;
        case (cur_size)
            2'd0: ld_data = {56'd0, win[7:0]};
            2'd1: begin
                ld_data = {48'd0, win[15:0]};
                misal   = cur_off[0];
            end
            2'd2: begin
                ld_data = {32'd0, win[31:0]};
                misal   = |cur_off[1:0];
            end
            default: begin
                ld_data = win;
                misal   = |cur_off[2:0];
            end
        endcase
    end

    assign rsp_done = cur_ld ? bus.ld_rsp_ready : bus.if_rsp_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= IDLE;
            last_ld          <= 1'b1;
            cur_ld           <= 1'b0;
            cur_tag          <= '0;
            cur_size         <= '0;
            cur_off          <= '0;
            bus.rom_addr     <= '0;
            bus.if_rsp_valid <= 1'b0;
            bus.if_rsp_data  <= '0;
            bus.if_rsp_tag   <= '0;
            bus.ld_rsp_valid <= 1'b0;
            bus.ld_rsp_data  <= '0;
            bus.ld_rsp_err   <= 1'b0;
            bus.ld_rsp_tag   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (gnt_ld) begin
                        cur_ld       <= 1'b1;
                        last_ld      <= 1'b1;
                        cur_tag      <= bus.ld_req_tag;
                        cur_size     <= bus.ld_req_size;
                        cur_off      <= bus.ld_req_addr[3:0];
                        bus.rom_addr <= bus.ld_req_addr[ADDR_W+3:4];
                        state        <= READ;
                    end else if (gnt_if) begin
                        cur_ld       <= 1'b0;
                        last_ld      <= 1'b0;
                        cur_tag      <= bus.if_req_tag;
                        bus.rom_addr <= bus.if_req_addr;
                        state        <= READ;
                    end
                end
                READ: begin
                    // Misaligned loads still spend the ROM cycle.
                    if (cur_ld) begin
                        bus.ld_rsp_valid <= 1'b1;
                        bus.ld_rsp_tag   <= cur_tag;
                        bus.ld_rsp_err   <= misal;
                        bus.ld_rsp_data  <= misal ? 64'd0 : ld_data;
                    end else begin
                        bus.if_rsp_valid <= 1'b1;
                        bus.if_rsp_tag   <= cur_tag;
                        bus.if_rsp_data  <= bus.rom_data;
                    end
                    state <= RESP;
                end
                RESP: begin
                    if (rsp_done) begin
                        bus.if_rsp_valid <= 1'b0;
                        bus.ld_rsp_valid <= 1'b0;
                        state            <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
